vec3_op_sequencer: RTL and testbench

Time-multiplexed vec3 arithmetic engine for the ray marcher. It accepts one vector operation per transaction (add, dot, cross, scale) and sequences it over a single shared fixed-point multiplier, one product per cycle. It replaces per-op combinational multiplier trees in the march loop and the shading stages. Requesters use valid/ready handshakes on both sides.

---
 rtl/vector_pkg.sv | 54 +++++
 rtl/vec3_op_sequencer_fp_mul.sv | 13 +
 rtl/vec3_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_vec3_op_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Fixed-point vec3 types, the shared Q16.16 multiply and the op encoding
// used by the vec3 sequencer.
package vector_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int FRAC_BITS  = 16;

  typedef logic signed [WORD_WIDTH-1:0] fp_t;

  // x occupies the least significant word of the flattened bus
  typedef struct packed {
    fp_t z;
    fp_t y;
    fp_t x;
  } vec3_t;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_DOT   = 2'd1,
    OP_CROSS = 2'd2,
    OP_SCALE = 2'd3
  } vec3_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Taking bits [47:16] of the full product is the arithmetic shift (floor).
  function automatic fp_t fp_mul(fp_t u, fp_t v);
    logic signed [2*WORD_WIDTH-1:0] p;
    p = (2*WORD_WIDTH)'(u) * (2*WORD_WIDTH)'(v);
    return p[FRAC_BITS +: WORD_WIDTH];
  endfunction

  function automatic logic [2:0] op_steps(vec3_op_e op);
    case (op)
      OP_ADD:   return 3'd1;
      OP_DOT:   return 3'd3;
      OP_SCALE: return 3'd3;
      default:  return 3'd6;
    endcase
  endfunction

  function automatic fp_t vec_comp(vec3_t v, logic [1:0] idx);
    case (idx)
      2'd0:    return v.x;
      2'd1:    return v.y;
      default: return v.z;
    endcase
  endfunction

endpackage

// File: rtl/vec3_op_sequencer_fp_mul.sv
// The one shared Q16.16 multiplier of the sequencer; kept as its own
// instance so the single-multiplier datapath is visible after synthesis.
module fp_mul_unit
  import vector_pkg::*;
(
  input  fp_t u_i,
  input  fp_t v_i,
  output fp_t p_o
);

  assign p_o = fp_mul(u_i, v_i);

endmodule

// File: rtl/vec3_op_sequencer.sv
// Time-multiplexed vec3 engine: ADD/DOT/CROSS/SCALE sequenced one product
// per cycle over a single fp_mul_unit, valid/ready on both sides.
module vec3_op_sequencer
  import vector_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [1:0]              in_op_i,
  input  logic [3*WORD_WIDTH-1:0] in_a_i,
  input  logic [3*WORD_WIDTH-1:0] in_b_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [3*WORD_WIDTH-1:0] out_res_o,
  output logic [15:0]             op_count_o
);

  seq_state_e  state_q, state_d;
  logic [2:0]  step_q, step_d;
  vec3_op_e    op_q, op_d;
  vec3_t       a_q, a_d, b_q, b_d, res_q, res_d;
  logic [15:0] op_count_q, op_count_d;
  fp_t         mul_u, mul_v, prod;
  logic        accept, retire, last_step;

  assign accept    = in_valid_i && (state_q == ST_IDLE);
  assign retire    = out_ready_i && (state_q == ST_DONE);
  assign last_step = (step_q == op_steps(op_q) - 3'd1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: if (out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    out_valid_o = (state_q == ST_DONE);
    out_res_o   = res_q;
    op_count_o  = op_count_q;
  end

  // Operand select for the shared multiplier, keyed by (op, step)
  always_comb begin
    mul_u = vec_comp(a_q, step_q[1:0]);
    mul_v = vec_comp(b_q, step_q[1:0]);
    case (op_q)
      OP_SCALE: mul_v = b_q.x;
      OP_CROSS: begin
        case (step_q)
          3'd0:    begin mul_u = a_q.y; mul_v = b_q.z; end
          3'd1:    begin mul_u = a_q.z; mul_v = b_q.y; end
          3'd2:    begin mul_u = a_q.z; mul_v = b_q.x; end
          3'd3:    begin mul_u = a_q.x; mul_v = b_q.z; end
          3'd4:    begin mul_u = a_q.x; mul_v = b_q.y; end
          default: begin mul_u = a_q.y; mul_v = b_q.x; end
        endcase
      end
      default: ;
    endcase
  end

  fp_mul_unit u_mul (
    .u_i (mul_u),
    .v_i (mul_v),
    .p_o (prod)
  );

  always_comb begin
    step_d     = step_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    op_count_d = op_count_q;
    if (accept) begin
      op_d   = vec3_op_e'(in_op_i);
      a_d    = in_a_i;
      b_d    = in_b_i;
      res_d  = '0;
      step_d = '0;
    end else if (state_q == ST_RUN) begin
      step_d = last_step ? step_q : step_q + 3'd1;
      case (op_q)
        OP_ADD: begin
          res_d.x = a_q.x + b_q.x;
          res_d.y = a_q.y + b_q.y;
          res_d.z = a_q.z + b_q.z;
        end
        OP_DOT: res_d.x = (step_q == 3'd0) ? prod : res_q.x + prod;
        OP_SCALE: begin
          case (step_q[1:0])
            2'd0:    res_d.x = prod;
            2'd1:    res_d.y = prod;
            default: res_d.z = prod;
          endcase
        end
        default: begin
          case (step_q)
            3'd0:    res_d.x = prod;
            3'd1:    res_d.x = res_q.x - prod;
            3'd2:    res_d.y = prod;
            3'd3:    res_d.y = res_q.y - prod;
            3'd4:    res_d.z = prod;
            default: res_d.z = res_q.z - prod;
          endcase
        end
      endcase
    end else if (retire) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      step_q     <= '0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      op_count_q <= '0;
    end else begin
      step_q     <= step_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      op_count_q <= op_count_d;
    end
  end

endmodule

// File: tb/tb_vec3_op_sequencer.sv
// Directed scoreboard bench for vec3_op_sequencer: latency, Q16.16 results,
// backpressure and mid-operation reset.
module tb_vec3_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [95:0] in_a, in_b, out_res;
  logic [15:0] op_count;

  int          checks = 0;
  int          errors = 0;
  logic [95:0] exp_q[$];
  logic [15:0] exp_count;

  always #5 clk = ~clk;

  vec3_op_sequencer dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_res_o   (out_res),
    .op_count_o  (op_count)
  );

  function automatic logic [31:0] fmul(logic [31:0] u, logic [31:0] v);
    longint p;
    p = longint'($signed(u)) * longint'($signed(v));
    p = p >>> 16;
    return p[31:0];
  endfunction

  function automatic logic [31:0] gc(logic [95:0] v, int i);
    return v[i*32 +: 32];
  endfunction

  function automatic logic [95:0] v3(logic [31:0] x, logic [31:0] y, logic [31:0] z);
    return {z, y, x};
  endfunction

  function automatic logic [95:0] model(logic [1:0] op, logic [95:0] a, logic [95:0] b);
    case (op)
      2'd0: return v3(gc(a,0) + gc(b,0), gc(a,1) + gc(b,1), gc(a,2) + gc(b,2));
      2'd1: return v3(fmul(gc(a,0), gc(b,0)) + fmul(gc(a,1), gc(b,1)) + fmul(gc(a,2), gc(b,2)),
                      32'd0, 32'd0);
      2'd2: return v3(fmul(gc(a,1), gc(b,2)) - fmul(gc(a,2), gc(b,1)),
                      fmul(gc(a,2), gc(b,0)) - fmul(gc(a,0), gc(b,2)),
                      fmul(gc(a,0), gc(b,1)) - fmul(gc(a,1), gc(b,0)));
      default: return v3(fmul(gc(a,0), gc(b,0)), fmul(gc(a,1), gc(b,0)), fmul(gc(a,2), gc(b,0)));
    endcase
  endfunction

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for the result and compare it against the scoreboard
  task automatic run_op(input logic [1:0] op, input logic [95:0] a, input logic [95:0] b,
                        input logic [95:0] exp, input string tag);
    int n;
    int cnt;
    logic [95:0] e;
    n = (op == 2'd0) ? 1 : (op == 2'd2) ? 6 : 3;
    exp_q.push_back(exp);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check({tag, " accept"}, in_ready, 96'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = ~op;
    in_a = {3{32'hDEAD_BEEF}};
    in_b = {3{32'h5A5A_A5A5}};
    cnt = 0;
    while (!out_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check({tag, " latency"}, cnt, n);
    e = exp_q.pop_front();
    check({tag, " res"}, out_res, e);
  endtask

  task automatic retire(input string tag);
    @(posedge clk); #1;
    exp_count++;
    check({tag, " in_ready after"}, in_ready, 96'd1);
    check({tag, " out_valid after"}, out_valid, 96'd0);
    check({tag, " op_count"}, op_count, exp_count);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] a, b, hold;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'd0; in_a = '0; in_b = '0;
    exp_count = 16'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset in_ready", in_ready, 96'd1);
    check("reset out_valid", out_valid, 96'd0);
    check("reset out_res", out_res, 96'd0);
    check("reset op_count", op_count, 96'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'd1, v3(32'h0001_0000, 32'h0002_0000, 32'h0003_0000),
           v3(32'h0004_0000, 32'h0005_0000, 32'h0006_0000),
           v3(32'h0020_0000, 32'd0, 32'd0), "dot123");
    retire("dot123");

    run_op(2'd2, v3(32'h0001_0000, 0, 0), v3(0, 32'h0001_0000, 0),
           v3(0, 0, 32'h0001_0000), "cross xy");
    retire("cross xy");
    run_op(2'd2, v3(0, 32'h0001_0000, 0), v3(32'h0001_0000, 0, 0),
           v3(0, 0, 32'hFFFF_0000), "cross yx");
    retire("cross yx");

    run_op(2'd3, v3(32'h0001_0000, 32'hFFFE_0000, 32'h0000_8000),
           v3(32'h0002_0000, 32'h1234_5678, 32'h9ABC_DEF0),
           v3(32'h0002_0000, 32'hFFFC_0000, 32'h0001_0000), "scale");
    retire("scale");

    run_op(2'd3, v3(32'hFFFF_FFFF, 0, 0), v3(32'h0000_8000, 32'hFFFF_FFFF, 32'h7777_7777),
           v3(32'hFFFF_FFFF, 0, 0), "scale floor");
    retire("scale floor");

    run_op(2'd0, v3(32'h7FFF_FFFF, 0, 0), v3(32'h0000_0001, 0, 0),
           v3(32'h8000_0000, 0, 0), "add wrap");
    retire("add wrap");

    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom};
      run_op(2'(i), a, b, model(2'(i), a, b), "rand");
      retire("rand");
    end

    // Backpressure: result must hold and new requests must be ignored
    out_ready = 1'b0;
    a = v3(32'h0003_0000, 32'hFFFF_0000, 32'h0000_4000);
    b = v3(32'h0002_0000, 32'h0007_0000, 32'hFFF8_0000);
    hold = model(2'd1, a, b);
    run_op(2'd1, a, b, hold, "bp dot");
    in_valid = 1'b1; in_op = 2'd0; in_a = '1; in_b = '1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp out_res stable", out_res, hold);
      check("bp in_ready low", in_ready, 96'd0);
      check("bp out_valid high", out_valid, 96'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    retire("bp release");

    // Reset while CROSS is at step 3
    in_op = 2'd2; in_valid = 1'b1;
    in_a = v3(32'h0001_0000, 32'h0002_0000, 32'h0003_0000);
    in_b = v3(32'h0004_0000, 32'h0005_0000, 32'h0006_0000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    check("mid-run in_ready low", in_ready, 96'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_count = 16'd0;
    check("rst mid in_ready", in_ready, 96'd1);
    check("rst mid out_valid", out_valid, 96'd0);
    check("rst mid out_res", out_res, 96'd0);
    check("rst mid op_count", op_count, 96'd0);

    a = v3(32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000);
    b = v3(32'h0000_8000, 32'hFFFE_0000, 32'h0003_0000);
    run_op(2'd0, a, b, v3(32'h0001_8000, 32'h0000_0000, 32'h0002_0000), "add post-rst");
    retire("add post-rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
